// File: rtl/mac_mul_negator_pipe.sv
// mac_mul_negator_pipe
// Two-stage valid/ready pipeline that turns packed A/B operand lanes into
// unsigned magnitudes for the unsigned multiplier array. Lanes are grouped
// into 1/2/4-lane operands by cfg[1:0]. Each group reports whether its
// product is negative. cfg travels with every beat, so the mode can change
// on any beat.
//
// cfg[3]   : signed operands
// cfg[2]   : mac/mul select, carried through untouched
// cfg[1:0] : 00 single, 01 dual, 10 quad, 11 single
module mac_mul_negator_pipe #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int NUM_LANES      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [MAC_CONF_WIDTH-1:0]          cfg,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_in,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_out,
  output logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_out,
  output logic [NUM_LANES-1:0]               neg_out,
  output logic [MAC_CONF_WIDTH-1:0]          cfg_out
);

  localparam int W  = MAC_MIN_WIDTH;
  localparam int N  = NUM_LANES;
  localparam int DW = N * W;

  // Stage 1: raw operands and their cfg
  logic                      s1_v_q, s1_v_d;
  logic [DW-1:0]             s1_a_q, s1_a_d;
  logic [DW-1:0]             s1_b_q, s1_b_d;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg_q, s1_cfg_d;

  // Stage 2: magnitudes, product signs and cfg as presented downstream
  logic                      s2_v_q, s2_v_d;
  logic [DW-1:0]             s2_a_q, s2_a_d;
  logic [DW-1:0]             s2_b_q, s2_b_d;
  logic [N-1:0]              s2_neg_q, s2_neg_d;
  logic [MAC_CONF_WIDTH-1:0] s2_cfg_q, s2_cfg_d;

  logic          s1_adv, s2_adv;
  logic          signed_en;
  logic [1:0]    mode;
  logic [DW-1:0] mag_a, mag_b;
  logic [N-1:0]  neg_c;

  // Combinational ready chain, no skid buffer: a stage may load when it is
  // empty or when the stage after it is draining in the same cycle.
  assign s2_adv   = en & (~s2_v_q | out_ready);
  assign s1_adv   = en & (~s1_v_q | s2_adv);
  assign in_ready = s1_adv;

  assign signed_en = s1_cfg_q[3];
  assign mode      = s1_cfg_q[1:0];

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic         lo;
    logic         sign_a, sign_b;
    logic         prev_a, prev_b;
    logic         cin_a, cin_b;
    logic         cout_a, cout_b;
    logic [W:0]   sum_a, sum_b;

    // The bottom lane has no lane below it; every other lane may chain from
    // its neighbour unless it starts a new group.
    if (i == 0) begin : g_base
      assign prev_a = 1'b1;
      assign prev_b = 1'b1;
    end else begin : g_link
      assign prev_a = g_lane[i-1].cout_a;
      assign prev_b = g_lane[i-1].cout_b;
    end

    // Per-lane negation slice: group sign from the group's top lane, +1 at the group base
    always_comb begin
      lo     = 1'b1;
      sign_a = s1_a_q[i*W + W-1];
      sign_b = s1_b_q[i*W + W-1];
      case (mode)
        2'b01: begin
          lo     = ((i % 2) == 0);
          sign_a = s1_a_q[(i | 1)*W + W-1];
          sign_b = s1_b_q[(i | 1)*W + W-1];
        end
        2'b10: begin
          lo     = ((i % 4) == 0);
          sign_a = s1_a_q[(i | 3)*W + W-1];
          sign_b = s1_b_q[(i | 3)*W + W-1];
        end
        default: ;
      endcase
      cin_a  = lo | prev_a;
      cin_b  = lo | prev_b;
      sum_a  = {1'b0, ~s1_a_q[i*W +: W]} + {{W{1'b0}}, cin_a};
      sum_b  = {1'b0, ~s1_b_q[i*W +: W]} + {{W{1'b0}}, cin_b};
      cout_a = sum_a[W];
      cout_b = sum_b[W];
    end

    // The most-negative value negates to itself, which is already the
    // correct unsigned magnitude, so no saturation is applied.
    assign mag_a[i*W +: W] = (signed_en & sign_a) ? sum_a[W-1:0] : s1_a_q[i*W +: W];
    assign mag_b[i*W +: W] = (signed_en & sign_b) ? sum_b[W-1:0] : s1_b_q[i*W +: W];
    assign neg_c[i]        = signed_en & (sign_a ^ sign_b);
  end

  // Next-state for both stages; data only moves when its stage advances
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_cfg_d = s1_cfg_q;
    s2_v_d   = s2_v_q;
    s2_a_d   = s2_a_q;
    s2_b_d   = s2_b_q;
    s2_neg_d = s2_neg_q;
    s2_cfg_d = s2_cfg_q;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d   = A_in;
        s1_b_d   = B_in;
        s1_cfg_d = cfg;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_a_d   = mag_a;
        s2_b_d   = mag_b;
        s2_neg_d = neg_c;
        s2_cfg_d = s1_cfg_q;
      end
    end
  end

  // Pipeline registers; reset clears everything so no stale beat can escape
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_cfg_q <= '0;
      s2_v_q   <= 1'b0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_neg_q <= '0;
      s2_cfg_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_cfg_q <= s1_cfg_d;
      s2_v_q   <= s2_v_d;
      s2_a_q   <= s2_a_d;
      s2_b_q   <= s2_b_d;
      s2_neg_q <= s2_neg_d;
      s2_cfg_q <= s2_cfg_d;
    end
  end

  assign out_valid = s2_v_q;
  assign A_out     = s2_a_q;
  assign B_out     = s2_b_q;
  assign neg_out   = s2_neg_q;
  assign cfg_out   = s2_cfg_q;

endmodule

// File: tb/tb_mac_mul_negator_pipe.sv
// Directed bench for mac_mul_negator_pipe with hand-computed vectors and an
// in-order queue of expected beats for the streaming sections.
module tb_mac_mul_negator_pipe;

  localparam int CW = 4;
  localparam int DW = 32;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] cfg;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] A_in, B_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] A_out, B_out;
  logic [3:0]    neg_out;
  logic [CW-1:0] cfg_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  v_cfg [NV];
  logic [31:0] v_a   [NV];
  logic [31:0] v_b   [NV];
  logic [31:0] e_a   [NV];
  logic [31:0] e_b   [NV];
  logic [3:0]  e_n   [NV];

  int exp_q[$];

  mac_mul_negator_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .neg_out   (neg_out),
    .cfg_out   (cfg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k);
    cfg  = v_cfg[k];
    A_in = v_a[k];
    B_in = v_b[k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int k);
    chk({tag, "_A"},   A_out,   e_a[k]);
    chk({tag, "_B"},   B_out,   e_b[k]);
    chk({tag, "_neg"}, neg_out, e_n[k]);
    chk({tag, "_cfg"}, cfg_out, v_cfg[k]);
  endtask

  // Streams beats first..first+count-1; out_ready is low in cycles [stall_lo, stall_hi)
  task automatic run_stream(input int first, input int count, input int stall_lo, input int stall_hi);
    int sent = 0;
    int cyc = 0;
    int k;
    logic          held = 1'b0;
    logic [DW-1:0] h_a, h_b;
    logic [3:0]    h_n;
    while ((sent < count || exp_q.size() > 0) && cyc < 100) begin
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      if (sent < count) begin
        in_valid = 1'b1;
        drive(first + sent);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (held) begin
        chk("held_valid", out_valid, 1'b1);
        chk("held_A", A_out, h_a);
        chk("held_B", B_out, h_b);
        chk("held_neg", neg_out, h_n);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1'b1, 1'b0);
        end else begin
          k = exp_q.pop_front();
          chk_beat("stream", k);
        end
      end
      held = out_valid && !out_ready;
      h_a  = A_out;
      h_b  = B_out;
      h_n  = neg_out;
      if (in_valid && in_ready) begin
        exp_q.push_back(first + sent);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_done", (cyc < 100), 1'b1);
    if (stall_lo < 0) chk("throughput_cycles", cyc, count + 2);
  endtask

  initial begin
    // single signed: lanes 80,01,FF,7F
    v_cfg[0] = 4'h8; v_a[0] = 32'h7FFF0180; v_b[0] = 32'h02020202;
    e_a[0] = 32'h7F010180; e_b[0] = 32'h02020202; e_n[0] = 4'b0101;
    // dual signed: FF00 -> 0100, upper B FFFE -> 0002 (no carry from lane 1)
    v_cfg[1] = 4'h9; v_a[1] = 32'h0005FF00; v_b[1] = 32'hFFFE0003;
    e_a[1] = 32'h00050100; e_b[1] = 32'h00020003; e_n[1] = 4'b1111;
    // quad signed
    v_cfg[2] = 4'hA; v_a[2] = 32'hFFFFFFFF; v_b[2] = 32'h80000000;
    e_a[2] = 32'h00000001; e_b[2] = 32'h80000000; e_n[2] = 4'b0000;
    // mode 11 behaves as single
    v_cfg[3] = 4'hB; v_a[3] = 32'hFE01FF80; v_b[3] = 32'h01010101;
    e_a[3] = 32'h02010180; e_b[3] = 32'h01010101; e_n[3] = 4'b1011;
    // unsigned single and unsigned quad: pass-through
    v_cfg[4] = 4'h0; v_a[4] = 32'hF0F0F0F0; v_b[4] = 32'h80FF0180;
    e_a[4] = 32'hF0F0F0F0; e_b[4] = 32'h80FF0180; e_n[4] = 4'b0000;
    v_cfg[5] = 4'h2; v_a[5] = 32'hF0F0F0F0; v_b[5] = 32'h80FF0180;
    e_a[5] = 32'hF0F0F0F0; e_b[5] = 32'h80FF0180; e_n[5] = 4'b0000;
    // same data, single then quad signed
    v_cfg[6] = 4'h8; v_a[6] = 32'hFFFFFFFF; v_b[6] = 32'h01020304;
    e_a[6] = 32'h01010101; e_b[6] = 32'h01020304; e_n[6] = 4'b1111;
    v_cfg[7] = 4'hA; v_a[7] = 32'hFFFFFFFF; v_b[7] = 32'h81020304;
    e_a[7] = 32'h00000001; e_b[7] = 32'h7EFDFCFC; e_n[7] = 4'b0000;
    // dual most-negative groups
    v_cfg[8] = 4'h9; v_a[8] = 32'h80008000; v_b[8] = 32'h00017FFF;
    e_a[8] = 32'h80008000; e_b[8] = 32'h00017FFF; e_n[8] = 4'b1111;
    // dual unsigned with MSBs set: pass-through
    v_cfg[9] = 4'h1; v_a[9] = 32'h80FF0180; v_b[9] = 32'hFFFFFFFF;
    e_a[9] = 32'h80FF0180; e_b[9] = 32'hFFFFFFFF; e_n[9] = 4'b0000;

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg = '0; A_in = '0; B_in = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_A", A_out, 32'h0);
    chk("rst_B", B_out, 32'h0);
    chk("rst_neg", neg_out, 4'h0);
    chk("rst_cfg", cfg_out, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Latency: accepted at one edge, visible after the next
    drive(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_s1_valid", out_valid, 1'b0);
    tick();
    chk("lat_s2_valid", out_valid, 1'b1);
    chk_beat("lat", 0);
    tick();
    chk("lat_drained", out_valid, 1'b0);

    // Back-to-back mixed modes with no stalls
    run_stream(1, 9, -1, -1);

    // Backpressure mid-stream
    run_stream(4, 6, 2, 5);

    // en=0 with a beat parked in S2
    out_ready = 1'b0;
    drive(6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("en_pre_valid", out_valid, 1'b1);
    en = 1'b0;
    out_ready = 1'b1;
    drive(7);
    in_valid = 1'b1;
    #1;
    chk("en_in_ready", in_ready, 1'b0);
    repeat (2) begin
      tick();
      chk("en_hold_valid", out_valid, 1'b1);
      chk_beat("en_hold", 6);
    end
    en = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("en_resume_ready", in_ready, 1'b1);
    tick();
    chk("en_drained", out_valid, 1'b0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(8);
    in_valid = 1'b1;
    tick();
    drive(9);
    tick();
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1'b1);
    chk("mid_full_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_A", A_out, 32'h0);
    chk("mid_rst_B", B_out, 32'h0);
    chk("mid_rst_neg", neg_out, 4'h0);
    chk("mid_rst_cfg", cfg_out, 4'h0);
    chk("mid_rst_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("mid_rst_no_ghost", out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
